// File: rtl/vga_timing_pkg.sv
// Shared types and timing presets for the parametrised VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  localparam timing_t VGA_640X480_60 = '{
    h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_active: 480, v_front: 10, v_sync: 2,  v_back: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_t SVGA_800X600_60 = '{
    h_active: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_active: 600, v_front: 1,  v_sync: 4,   v_back: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  function automatic int unsigned seg_total(input int unsigned sync_len,
                                            input int unsigned back_len,
                                            input int unsigned active_len,
                                            input int unsigned front_len);
    return sync_len + back_len + active_len + front_len;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Run request and raster outputs between the timing generator and the pixel source.
interface vga_timing_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
) ();

  logic           enable;
  logic           HS;
  logic           VS;
  logic           de;
  logic           fetch;
  logic [X_W-1:0] CoorX;
  logic [Y_W-1:0] CoorY;
  logic           line_start;
  logic           frame_start;
  logic           running;

  modport master (
    input  enable,
    output HS, VS, de, fetch, CoorX, CoorY, line_start, frame_start, running
  );

  modport slave (
    output enable,
    input  HS, VS, de, fetch, CoorX, CoorY, line_start, frame_start, running
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-aligned stop, pixel-fetch lead and
// line/frame start strobes. Every output is registered one cycle after the count it decodes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned FETCH_LEAD = 2,
  parameter int unsigned X_W        = 11,
  parameter int unsigned Y_W        = 10
) (
  input  logic         vga_clk,
  input  logic         reset,
  vga_timing_if.master bus
);

  localparam int unsigned H_TOTAL = seg_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int unsigned V_TOTAL = seg_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_SYNC_X = X_W'(H_SYNC);
  localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_DE_LO  = X_W'(H_SYNC + H_BACK);
  localparam logic [X_W-1:0] H_F_LO   = X_W'(H_SYNC + H_BACK - FETCH_LEAD);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_SYNC_Y = Y_W'(V_SYNC);
  localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_LO     = Y_W'(V_SYNC + V_BACK);

  state_e         state_q;
  logic [X_W-1:0] h_q;
  logic [Y_W-1:0] v_q;

  logic           hs_q, vs_q, de_q, fetch_q;
  logic           line_start_q, frame_start_q, running_q;
  logic [X_W-1:0] coor_x_q;
  logic [Y_W-1:0] coor_y_q;

  // Window tests by offset: counts below the window wrap to values >= the active length,
  // because the counter width already holds the full line/frame total.
  logic [X_W-1:0] de_off, fetch_off;
  logic [Y_W-1:0] row_off;
  logic           h_in_de, h_in_fetch, v_in;
  logic           frame_end, stop_pending, run_next;

  assign de_off     = h_q - H_DE_LO;
  assign fetch_off  = h_q - H_F_LO;
  assign row_off    = v_q - V_LO;
  assign h_in_de    = de_off < H_ACT_X;
  assign h_in_fetch = fetch_off < H_ACT_X;
  assign v_in       = row_off < V_ACT_Y;
  assign frame_end  = (h_q == H_LAST) && (v_q == V_LAST);

  // The flag is set or cleared by enable every RUN cycle, so its updated value is ~enable.
  assign stop_pending = ~bus.enable;
  assign run_next     = (state_q == RUN) ? !(frame_end && stop_pending) : bus.enable;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      fetch_q       <= 1'b0;
      coor_x_q      <= H_ACT_X;
      coor_y_q      <= V_ACT_Y;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q   <= run_next ? RUN : IDLE;
      running_q <= run_next;
      if (state_q == RUN) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
        end else begin
          h_q <= h_q + X_W'(1);
        end
        hs_q          <= (h_q < H_SYNC_X) ? HS_POL : ~HS_POL;
        vs_q          <= (v_q < V_SYNC_Y) ? VS_POL : ~VS_POL;
        de_q          <= h_in_de && v_in;
        fetch_q       <= h_in_fetch && v_in;
        coor_x_q      <= (h_in_fetch && v_in) ? fetch_off : H_ACT_X;
        coor_y_q      <= (h_in_fetch && v_in) ? row_off : V_ACT_Y;
        line_start_q  <= (h_q == '0);
        frame_start_q <= (h_q == '0) && (v_q == '0);
      end else begin
        hs_q          <= ~HS_POL;
        vs_q          <= ~VS_POL;
        de_q          <= 1'b0;
        fetch_q       <= 1'b0;
        coor_x_q      <= H_ACT_X;
        coor_y_q      <= V_ACT_Y;
        line_start_q  <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

  assign bus.HS          = hs_q;
  assign bus.VS          = vs_q;
  assign bus.de          = de_q;
  assign bus.fetch       = fetch_q;
  assign bus.CoorX       = coor_x_q;
  assign bus.CoorY       = coor_y_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus queues hand-computed output snapshots per cycle, a negedge
// monitor pops and compares them; three instances cover default and small timings.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_timing_if #(.X_W(11), .Y_W(10)) ifa ();
  vga_timing_if #(.X_W(4),  .Y_W(3))  ifb ();
  vga_timing_if #(.X_W(4),  .Y_W(3))  ifc ();

  vga_timing_gen dut_a (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (ifa.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .FETCH_LEAD(0), .X_W(4), .Y_W(3)
  ) dut_b (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (ifb.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .FETCH_LEAD(3), .X_W(4), .Y_W(3)
  ) dut_c (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (ifc.master)
  );

  typedef struct {
    int unsigned cyc;
    int          dut;
    int          tag;
    logic [27:0] vec;
  } exp_t;

  exp_t sb[$];

  // Snapshot order: running, frame_start, line_start, fetch, de, VS, HS, CoorY, CoorX.
  function automatic logic [27:0] mk(input logic r, input logic fs, input logic ls,
                                     input logic f, input logic d, input logic vs,
                                     input logic hs, input int cy, input int cx);
    return {r, fs, ls, f, d, vs, hs, 10'(cy), 11'(cx)};
  endfunction

  task automatic push(input int dut, input int unsigned at, input int tag,
                      input logic [27:0] v);
    exp_t e;
    e.cyc = at;
    e.dut = dut;
    e.tag = tag;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  int cnt_de_b = 0, cnt_fetch_b = 0, cnt_ls_b = 0, cnt_fs_b = 0;
  int cnt_vs_b = 0, cnt_hs_b = 0, cnt_fne_b = 0, cnt_de_c = 0, cnt_fetch_c = 0;

  always @(negedge clk) begin
    logic [27:0] va, vb, vc, got;
    va = {ifa.running, ifa.frame_start, ifa.line_start, ifa.fetch, ifa.de, ifa.VS, ifa.HS,
          10'(ifa.CoorY), 11'(ifa.CoorX)};
    vb = {ifb.running, ifb.frame_start, ifb.line_start, ifb.fetch, ifb.de, ifb.VS, ifb.HS,
          10'(ifb.CoorY), 11'(ifb.CoorX)};
    vc = {ifc.running, ifc.frame_start, ifc.line_start, ifc.fetch, ifc.de, ifc.VS, ifc.HS,
          10'(ifc.CoorY), 11'(ifc.CoorX)};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        got = (sb[i].dut == 0) ? va : (sb[i].dut == 1) ? vb : vc;
        n_cmp++;
        if (got !== sb[i].vec) begin
          n_fail++;
          $display("FAIL dut%0d step %0d: got %h, expected %h", sb[i].dut, sb[i].tag, got,
                   sb[i].vec);
        end
        sb.delete(i);
      end
    end
    cnt_de_b    += int'(ifb.de);
    cnt_fetch_b += int'(ifb.fetch);
    cnt_ls_b    += int'(ifb.line_start);
    cnt_fs_b    += int'(ifb.frame_start);
    cnt_vs_b    += int'(ifb.VS == 1'b0);
    cnt_hs_b    += int'(ifb.HS == 1'b1);
    if (ifb.fetch != ifb.de) cnt_fne_b++;
    cnt_de_c    += int'(ifc.de);
    cnt_fetch_c += int'(ifc.fetch);
  end

  task automatic wait_neg(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic after_edge(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not end, expected completion before 3 ms");
    $fatal(1, "watchdog");
  end

  int unsigned t0, t1;
  int s_de, s_fetch, s_ls, s_fs, s_vs, s_hs, s_de_c, s_fetch_c;

  initial begin
    reset = 1'b1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    ifc.enable = 1'b0;
    repeat (3) @(negedge clk);
    push(0, cyc + 1, -1, mk(0, 0, 0, 0, 0, 1, 1, 480, 640));
    push(1, cyc + 1, -1, mk(0, 0, 0, 0, 0, 1, 0, 2, 4));
    push(2, cyc + 1, -1, mk(0, 0, 0, 0, 0, 0, 1, 2, 4));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Sample n (outputs after enable-edge E_n) lands at cyc t0+1+n.
    t0 = cyc;
    push(0, t0 + 1,     0,     mk(1, 0, 0, 0, 0, 1, 1, 480, 640));
    push(0, t0 + 2,     1,     mk(1, 1, 1, 0, 0, 0, 0, 480, 640));
    push(0, t0 + 3,     2,     mk(1, 0, 0, 0, 0, 0, 0, 480, 640));
    push(0, t0 + 97,    96,    mk(1, 0, 0, 0, 0, 0, 0, 480, 640));
    push(0, t0 + 98,    97,    mk(1, 0, 0, 0, 0, 0, 1, 480, 640));
    push(0, t0 + 802,   801,   mk(1, 0, 1, 0, 0, 0, 0, 480, 640));
    push(0, t0 + 1602,  1601,  mk(1, 0, 1, 0, 0, 1, 0, 480, 640));
    push(0, t0 + 28143, 28142, mk(1, 0, 0, 0, 0, 1, 1, 480, 640));
    push(0, t0 + 28144, 28143, mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
    push(0, t0 + 28145, 28144, mk(1, 0, 0, 1, 0, 1, 1, 0, 1));
    push(0, t0 + 28146, 28145, mk(1, 0, 0, 1, 1, 1, 1, 0, 2));
    push(0, t0 + 28783, 28782, mk(1, 0, 0, 1, 1, 1, 1, 0, 639));
    push(0, t0 + 28784, 28783, mk(1, 0, 0, 0, 1, 1, 1, 480, 640));
    push(0, t0 + 28785, 28784, mk(1, 0, 0, 0, 1, 1, 1, 480, 640));
    push(0, t0 + 28786, 28785, mk(1, 0, 0, 0, 0, 1, 1, 480, 640));
    push(0, t0 + 28944, 28943, mk(1, 0, 0, 1, 0, 1, 1, 1, 0));
    push(0, t0 + 28951, 28950, mk(1, 0, 0, 1, 1, 1, 1, 1, 7));

    push(1, t0 + 1,  0,  mk(1, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t0 + 2,  1,  mk(1, 1, 1, 0, 0, 0, 1, 2, 4));
    push(1, t0 + 3,  2,  mk(1, 0, 0, 0, 0, 0, 1, 2, 4));
    push(1, t0 + 4,  3,  mk(1, 0, 0, 0, 0, 0, 0, 2, 4));
    push(1, t0 + 10, 9,  mk(1, 0, 1, 0, 0, 1, 1, 2, 4));
    push(1, t0 + 21, 20, mk(1, 0, 0, 1, 1, 1, 0, 0, 0));
    push(1, t0 + 24, 23, mk(1, 0, 0, 1, 1, 1, 0, 0, 3));
    push(1, t0 + 25, 24, mk(1, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t0 + 29, 28, mk(1, 0, 0, 1, 1, 1, 0, 1, 0));
    push(1, t0 + 32, 31, mk(1, 0, 0, 1, 1, 1, 0, 1, 3));
    push(1, t0 + 37, 36, mk(1, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t0 + 42, 41, mk(1, 1, 1, 0, 0, 0, 1, 2, 4));
    push(1, t0 + 61, 60, mk(1, 0, 0, 1, 1, 1, 0, 0, 0));
    push(1, t0 + 80, 79, mk(1, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t0 + 81, 80, mk(0, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t0 + 96, 95, mk(0, 0, 0, 0, 0, 1, 0, 2, 4));

    push(2, t0 + 1,  0,  mk(1, 0, 0, 0, 0, 0, 1, 2, 4));
    push(2, t0 + 2,  1,  mk(1, 1, 1, 0, 0, 1, 0, 2, 4));
    push(2, t0 + 10, 9,  mk(1, 0, 1, 0, 0, 0, 0, 2, 4));
    push(2, t0 + 18, 17, mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
    push(2, t0 + 20, 19, mk(1, 0, 0, 1, 0, 0, 1, 0, 2));
    push(2, t0 + 21, 20, mk(1, 0, 0, 1, 1, 0, 1, 0, 3));
    push(2, t0 + 22, 21, mk(1, 0, 0, 0, 1, 0, 1, 2, 4));
    push(2, t0 + 25, 24, mk(1, 0, 0, 0, 0, 0, 1, 2, 4));
    push(2, t0 + 26, 25, mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
    push(2, t0 + 34, 33, mk(1, 0, 1, 0, 0, 0, 0, 2, 4));

    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    ifc.enable = 1'b1;

    // One full small frame: samples 1..40.
    after_edge(t0 + 2);
    s_de = cnt_de_b; s_fetch = cnt_fetch_b; s_ls = cnt_ls_b; s_fs = cnt_fs_b;
    s_vs = cnt_vs_b; s_hs = cnt_hs_b; s_de_c = cnt_de_c; s_fetch_c = cnt_fetch_c;
    after_edge(t0 + 42);
    check("b_frame_de",          cnt_de_b - s_de, 8);
    check("b_frame_fetch",       cnt_fetch_b - s_fetch, 8);
    check("b_frame_line_start",  cnt_ls_b - s_ls, 5);
    check("b_frame_frame_start", cnt_fs_b - s_fs, 1);
    check("b_frame_vs_active",   cnt_vs_b - s_vs, 8);
    check("b_frame_hs_active",   cnt_hs_b - s_hs, 10);
    check("c_frame_de",          cnt_de_c - s_de_c, 8);
    check("c_frame_fetch",       cnt_fetch_c - s_fetch_c, 8);
    s_de = cnt_de_b; s_fs = cnt_fs_b;

    // Drop enable mid-frame: the second frame must still complete.
    wait_neg(t0 + 50);
    ifb.enable = 1'b0;
    after_edge(t0 + 82);
    check("b_stop_frame_de",    cnt_de_b - s_de, 8);
    check("b_stop_frame_start", cnt_fs_b - s_fs, 1);
    s_de = cnt_de_b; s_ls = cnt_ls_b; s_fs = cnt_fs_b;
    after_edge(t0 + 102);
    check("b_idle_de",          cnt_de_b - s_de, 0);
    check("b_idle_line_start",  cnt_ls_b - s_ls, 0);
    check("b_idle_frame_start", cnt_fs_b - s_fs, 0);

    // Restart, then a short enable dip inside the frame must not break the raster.
    wait_neg(t0 + 110);
    t1 = cyc;
    push(1, t1 + 1,  100, mk(1, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t1 + 2,  101, mk(1, 1, 1, 0, 0, 0, 1, 2, 4));
    push(1, t1 + 16, 115, mk(1, 0, 0, 0, 0, 1, 0, 2, 4));
    push(1, t1 + 21, 120, mk(1, 0, 0, 1, 1, 1, 0, 0, 0));
    push(1, t1 + 42, 141, mk(1, 1, 1, 0, 0, 0, 1, 2, 4));
    ifb.enable = 1'b1;
    after_edge(t1 + 2);
    s_de = cnt_de_b; s_ls = cnt_ls_b; s_fs = cnt_fs_b;
    wait_neg(t1 + 10);
    ifb.enable = 1'b0;
    wait_neg(t1 + 20);
    ifb.enable = 1'b1;
    after_edge(t1 + 82);
    check("b_dip_frame_start", cnt_fs_b - s_fs, 2);
    check("b_dip_de",          cnt_de_b - s_de, 16);
    check("b_dip_line_start",  cnt_ls_b - s_ls, 10);
    check("b_fetch_vs_de",     cnt_fne_b, 0);

    // Asynchronous reset while all three are running, away from any rising edge.
    wait_neg(t0 + 28951);
    @(posedge clk);
    #2;
    reset = 1'b1;
    push(0, cyc, -2, mk(0, 0, 0, 0, 0, 1, 1, 480, 640));
    push(1, cyc, -2, mk(0, 0, 0, 0, 0, 1, 0, 2, 4));
    push(2, cyc, -2, mk(0, 0, 0, 0, 0, 0, 1, 2, 4));
    repeat (2) @(negedge clk);
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    ifc.enable = 1'b0;
    reset = 1'b0;
    push(0, cyc + 1, -3, mk(0, 0, 0, 0, 0, 1, 1, 480, 640));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
